// File: rtl/scc_tone_generator.sv
// Five-channel SCC tone engine: steps per-channel period counters and wave phases,
// issues wave-RAM reads, scales returned samples by volume and mixes one sample per frame.
module scc_tone_generator #(
  parameter int MIX_WIDTH = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           active,
  input  logic [11:0]          reg_frequency_count0,
  input  logic [3:0]           reg_volume0,
  input  logic                 reg_enable0,
  input  logic [4:0]           phase_reset,
  output logic                 wave_req,
  output logic [2:0]           wave_id,
  output logic [4:0]           wave_a,
  input  logic [7:0]           wave_q,
  output logic [MIX_WIDTH-1:0] sound_out,
  output logic                 sound_valid
);

  function automatic logic signed [11:0] scale(input logic signed [7:0] s, input logic [3:0] v);
    logic signed [12:0] a;
    logic signed [12:0] b;
    logic signed [12:0] full;
    a    = s;
    b    = $signed({1'b0, v});
    full = a * b;
    return full[11:0];
  endfunction

  function automatic logic signed [MIX_WIDTH-1:0] ext(input logic signed [11:0] x);
    return MIX_WIDTH'(x);
  endfunction

  logic [11:0]                 cnt       [5];
  logic [4:0]                  phase     [5];
  logic [4:0]                  rst_pend;
  logic [11:0]                 cnt_nxt   [5];
  logic [4:0]                  phase_nxt [5];
  logic [4:0]                  pend_nxt;
  logic [4:0]                  wave_a_nxt;
  logic signed [11:0]          prod_p1;
  logic signed [MIX_WIDTH-1:0] term_p2;
  logic signed [MIX_WIDTH-1:0] acc_p2;
  logic                        frame_seen;

  always_comb begin
    wave_a_nxt = 5'd0;
    pend_nxt   = rst_pend | phase_reset;
    for (int c = 0; c < 5; c++) begin
      cnt_nxt[c]   = cnt[c];
      phase_nxt[c] = phase[c];
      if (active == 3'(c)) begin
        if (pend_nxt[c]) begin
          phase_nxt[c] = 5'd0;
          cnt_nxt[c]   = reg_frequency_count0;
          pend_nxt[c]  = 1'b0;
        end else if (reg_frequency_count0 >= 12'd9) begin
          // Frequencies below 9 freeze the channel entirely
          if (cnt[c] == 12'd0) begin
            cnt_nxt[c]   = reg_frequency_count0;
            phase_nxt[c] = phase[c] + 5'd1;
          end else begin
            cnt_nxt[c] = cnt[c] - 12'd1;
          end
        end
        wave_a_nxt = phase_nxt[c];
      end
    end
  end

  // Stage p0: slot update and wave-RAM read request
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < 5; c++) begin
        cnt[c]   <= 12'd0;
        phase[c] <= 5'd0;
      end
      rst_pend <= 5'd0;
      wave_req <= 1'b0;
      wave_id  <= 3'd0;
      wave_a   <= 5'd0;
    end else begin
      for (int c = 0; c < 5; c++) begin
        cnt[c]   <= cnt_nxt[c];
        phase[c] <= phase_nxt[c];
      end
      rst_pend <= pend_nxt;
      if (active <= 3'd4) begin
        wave_req <= 1'b1;
        wave_id  <= active;
        wave_a   <= wave_a_nxt;
      end else begin
        wave_req <= 1'b0;
      end
    end
  end

  // Stage p1: volume scaling of the returned sample
  always_ff @(posedge clk) begin
    prod_p1 <= scale($signed(wave_q), reg_volume0);
  end

  assign term_p2 = reg_enable0 ? ext(prod_p1) : '0;

  // Stage p2: gated accumulation, channel A opens the frame and E closes it
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_p2      <= '0;
      sound_out   <= '0;
      sound_valid <= 1'b0;
      frame_seen  <= 1'b0;
    end else begin
      sound_valid <= 1'b0;
      case (active)
        3'd4: begin
          acc_p2     <= term_p2;
          frame_seen <= 1'b1;
        end
        3'd5, 3'd0, 3'd1: acc_p2 <= acc_p2 + term_p2;
        3'd2: begin
          if (frame_seen) begin
            sound_out   <= acc_p2 + term_p2;
            sound_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scc_tone_generator.sv
// Directed bench for scc_tone_generator: drives the slot sequence, models the
// register-block timing of volume/enable/wave data and checks reads and mix output.
module tb_scc_tone_generator;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  active;
  logic [11:0] reg_frequency_count0;
  logic [3:0]  reg_volume0;
  logic        reg_enable0;
  logic [4:0]  phase_reset;
  logic        wave_req;
  logic [2:0]  wave_id;
  logic [4:0]  wave_a;
  logic [7:0]  wave_q;
  logic [14:0] sound_out;
  logic        sound_valid;

  scc_tone_generator #(.MIX_WIDTH(15)) dut (
    .clk(clk), .reset(reset), .active(active),
    .reg_frequency_count0(reg_frequency_count0), .reg_volume0(reg_volume0),
    .reg_enable0(reg_enable0), .phase_reset(phase_reset),
    .wave_req(wave_req), .wave_id(wave_id), .wave_a(wave_a), .wave_q(wave_q),
    .sound_out(sound_out), .sound_valid(sound_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]      en;
    logic [4:0][7:0] q;
    logic [4:0][3:0] vol;
    int              exp;
  } vec_t;

  vec_t            tv [10];
  logic [11:0]     freq [5];
  logic [4:0][7:0] cfg_q;
  logic [4:0][3:0] cfg_vol;
  logic [4:0]      cfg_en;
  logic [4:0]      pr;
  int              last_a [5];
  int              vis [5];
  int              last_sound;
  int              nvalid;
  int              total;
  int              bad;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  // Register block: volume lags the slot by 3, enable by 4; RAM data lags the request by 2
  task automatic step();
    int a, cv, ce;
    a  = int'(active);
    cv = (a + 3) % 6;
    ce = (a + 2) % 6;
    reg_frequency_count0 = (a < 5) ? freq[a] : 12'd0;
    wave_q      = (cv < 5) ? cfg_q[cv] : 8'd0;
    reg_volume0 = (cv < 5) ? cfg_vol[cv] : 4'd0;
    reg_enable0 = (ce < 5) ? cfg_en[ce] : 1'b0;
    phase_reset = pr;
    @(posedge clk);
    #1;
    if (wave_req && wave_id < 3'd5) begin
      last_a[wave_id] = int'(wave_a);
      vis[wave_id]++;
    end
    if (sound_valid) begin
      last_sound = int'($signed(sound_out));
      nvalid++;
    end
    active = (active == 3'd5) ? 3'd0 : active + 3'd1;
  endtask

  task automatic sync_to(input int a);
    while (int'(active) != a) step();
  endtask

  task automatic visit_ch(input int c, input int n);
    int start, steps;
    start = vis[c];
    steps = 0;
    while (vis[c] < start + n && steps < 6 * n + 12) begin
      step();
      steps++;
    end
    check($sformatf("visits_ch%0d", c), vis[c] - start, n);
  endtask

  task automatic pulse_pr(input logic [4:0] m);
    pr = m;
    step();
    pr = 5'd0;
  endtask

  initial begin
    int n0;
    total = 0; bad = 0; nvalid = 0; last_sound = 0;
    for (int c = 0; c < 5; c++) begin
      freq[c] = 12'd9; last_a[c] = -1; vis[c] = 0;
    end
    cfg_q   = {5{8'h7F}};
    cfg_vol = {5{4'd15}};
    cfg_en  = 5'b00001;
    pr      = 5'd0;
    reset   = 1'b1;
    active  = 3'd0;
    tv[0] = '{5'h1F, {5{8'h80}}, {5{4'd15}}, -9600};
    tv[1] = '{5'h1B, {5{8'h80}}, {5{4'd15}}, -7680};
    tv[2] = '{5'h01, {5{8'h7F}}, {5{4'd15}}, 1905};
    tv[3] = '{5'h1F, {5{8'h7F}}, {5{4'd15}}, 9525};
    tv[4] = '{5'h1F, {5{8'h01}}, {5{4'd1}}, 5};
    tv[5] = '{5'h00, {5{8'h7F}}, {5{4'd15}}, 0};
    tv[6] = '{5'h1F, {5{8'hFF}}, {5{4'd3}}, -15};
    tv[7] = '{5'h10, {5{8'h80}}, {5{4'd1}}, -128};
    tv[8] = '{5'h05, {5{8'h40}}, {5{4'd8}}, 1024};
    tv[9] = '{5'h03, {8'h00, 8'h00, 8'h00, 8'h80, 8'h7F}, {5{4'd15}}, -15};

    // Reset held across a whole slot cycle
    repeat (6) step();
    check("rst_wave_req", int'(wave_req), 0);
    check("rst_wave_id", int'(wave_id), 0);
    check("rst_wave_a", int'(wave_a), 0);
    check("rst_sound_out", int'(sound_out), 0);
    check("rst_sound_valid", int'(sound_valid), 0);

    reset = 1'b0;
    step();
    check("first_req", int'(wave_req), 1);
    check("first_id", int'(wave_id), 0);
    check("first_a", int'(wave_a), 1);
    step(); step();
    check("no_valid_before_A", nvalid, 0);
    repeat (3) step();
    check("idle_slot_req", int'(wave_req), 0);
    step(); step(); step();
    check("first_valid", int'(sound_valid), 1);
    check("first_sound", last_sound, 1905);
    step();
    check("valid_one_clock", int'(sound_valid), 0);

    // Ch A at F=9 advances phase every 10 visits
    sync_to(5);
    pulse_pr(5'b00001);
    visit_ch(0, 1);  check("A_visit1", last_a[0], 0);
    visit_ch(0, 9);  check("A_visit10", last_a[0], 0);
    visit_ch(0, 1);  check("A_visit11", last_a[0], 1);
    n0 = nvalid;
    visit_ch(0, 10); check("A_visit21", last_a[0], 2);
    check("A_frames", nvalid - n0, 10);
    check("A_sound", last_sound, 1905);

    // Ch A halted with count mid-way, then resumed
    sync_to(5);
    pulse_pr(5'b00001);
    visit_ch(0, 4);
    freq[0] = 12'd5;
    for (int i = 0; i < 200; i++) begin
      step();
      if (wave_req && wave_id == 3'd0) check("halt_a", int'(wave_a), 0);
    end
    freq[0] = 12'd9;
    visit_ch(0, 6); check("resume_cnt_held", last_a[0], 0);
    visit_ch(0, 1); check("resume_step", last_a[0], 1);

    // Mix table
    for (int i = 0; i < 10; i++) begin
      cfg_en  = tv[i].en;
      cfg_q   = tv[i].q;
      cfg_vol = tv[i].vol;
      sync_to(0);
      n0 = nvalid;
      repeat (12) step();
      check($sformatf("mix_count[%0d]", i), nvalid - n0, 2);
      check($sformatf("mix[%0d]", i), last_sound, tv[i].exp);
    end

    // Reset mid-frame drops the partial sum and the next early slot 2
    cfg_en = 5'h1F; cfg_q = {5{8'h80}}; cfg_vol = {5{4'd15}};
    sync_to(5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    n0 = nvalid;
    step(); step(); step();
    check("midrst_no_valid", nvalid - n0, 0);
    repeat (6) step();
    check("midrst_valid", nvalid - n0, 1);
    check("midrst_sound", last_sound, -9600);

    // Ch B phase wrap 31 -> 0
    sync_to(0);
    pulse_pr(5'b00010);
    visit_ch(1, 1);   check("B_start", last_a[1], 0);
    visit_ch(1, 310); check("B_phase31", last_a[1], 31);
    visit_ch(1, 9);   check("B_still31", last_a[1], 31);
    visit_ch(1, 1);   check("B_wrap", last_a[1], 0);

    // Ch D phase reset mid-count and coincident with service
    freq[3] = 12'd20;
    sync_to(0);
    pulse_pr(5'b01000);
    visit_ch(3, 1);  check("D_start", last_a[3], 0);
    visit_ch(3, 21); check("D_phase1", last_a[3], 1);
    visit_ch(3, 3);
    sync_to(1);
    pulse_pr(5'b01000);
    visit_ch(3, 1);  check("D_reset_a", last_a[3], 0);
    visit_ch(3, 20); check("D_reload_hold", last_a[3], 0);
    visit_ch(3, 1);  check("D_reload_step", last_a[3], 1);
    sync_to(3);
    pulse_pr(5'b01000);
    check("D_coinc_id", int'(wave_id), 3);
    check("D_coinc_a", int'(wave_a), 0);
    visit_ch(3, 1);  check("D_after_coinc", last_a[3], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
